// File: rtl/leve_axir_mem_if.sv
// AXI read-channel bundle (AR + R) shared by the fetch initiator and memory-backed targets.
// The init/target modports are the canonical views; master/slave alias them for generic bus code.
interface AXIR;
  // Both channels use strict valid/ready: a beat transfers on a rising edge where valid && ready,
  // and the source holds its payload stable while valid is high and ready is low.
  logic         ARVALID;
  logic         ARREADY;
  logic [31:0]  ARADDR;
  logic [1:0]   ARBURST;
  logic [7:0]   ARLEN;
  logic         RVALID;
  logic         RREADY;
  logic [127:0] RDATA;
  logic         RLAST;
  logic [1:0]   RRESP;

  modport init   (output ARVALID, ARADDR, ARBURST, ARLEN, RREADY,
                  input  ARREADY, RVALID, RDATA, RLAST, RRESP);
  modport target (input  ARVALID, ARADDR, ARBURST, ARLEN, RREADY,
                  output ARREADY, RVALID, RDATA, RLAST, RRESP);
  modport master (output ARVALID, ARADDR, ARBURST, ARLEN, RREADY,
                  input  ARREADY, RVALID, RDATA, RLAST, RRESP);
  modport slave  (input  ARVALID, ARADDR, ARBURST, ARLEN, RREADY,
                  output ARREADY, RVALID, RDATA, RLAST, RRESP);
endinterface

// File: rtl/leve_axir_mem.sv
// AXI read responder over a 128-bit memory with FIXED/INCR/WRAP bursts and a preload write port.
// Define LEVE_AXIR_MEM_WAIT_EN to insert LATENCY wait cycles before the first beat.
module leve_axir_mem #(
  parameter int  DEPTH   = 1024,
  parameter int  LATENCY = 2,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic          CLK,
  input  logic          RSTn,
  input  logic          MEM_WE,
  input  logic [AW-1:0] MEM_WADDR,
  input  logic [127:0]  MEM_WDATA,
  AXIR.target           RIT
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_BURST = 2'd2} state_t;

  state_t        state, next_state;
  logic [127:0]  mem [DEPTH];
  logic [AW-1:0] idx, start_idx, next_idx, fetch_idx, len_mask;
  logic [1:0]    burst;
  logic [7:0]    len, beat;
  logic          err, start_err, fetch_err, load, fetch, last;
  logic [127:0]  rdata, fetch_data;
  logic          unused_bits;

  assign start_idx = RIT.ARADDR[AW+3:4];
  assign start_err = (RIT.ARBURST == 2'd3) ||
                     ((RIT.ARBURST == 2'd2) && !(RIT.ARLEN inside {8'd1, 8'd3, 8'd7, 8'd15}));
  assign len_mask  = AW'(len);
  assign last      = (beat == len);

  // WRAP keeps the bits above the (len+1)-aligned window and cycles only the low offset.
  always_comb begin
    case (burst)
      2'd1:    next_idx = idx + AW'(1);
      2'd2:    next_idx = (idx & ~len_mask) | ((idx + AW'(1)) & len_mask);
      default: next_idx = idx;
    endcase
  end

`ifdef LEVE_AXIR_MEM_WAIT_EN
  logic [3:0] cnt;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn)                               cnt <= '0;
    else if (load)                           cnt <= 4'(LATENCY - 1);
    else if (state == S_WAIT && cnt != '0)   cnt <= cnt - 4'd1;
  end
`endif

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) state <= S_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    load       = 1'b0;
    fetch      = 1'b0;
    fetch_idx  = idx;
    case (state)
      S_IDLE: begin
        if (RIT.ARVALID) begin
          load = 1'b1;
`ifdef LEVE_AXIR_MEM_WAIT_EN
          next_state = S_WAIT;
`else
          next_state = S_BURST;
          fetch      = 1'b1;
          fetch_idx  = start_idx;
`endif
        end
      end
`ifdef LEVE_AXIR_MEM_WAIT_EN
      S_WAIT: begin
        if (cnt == '0) begin
          next_state = S_BURST;
          fetch      = 1'b1;
        end
      end
`endif
      S_BURST: begin
        if (RIT.RREADY) begin
          if (last) begin
            next_state = S_IDLE;
          end else begin
            fetch     = 1'b1;
            fetch_idx = next_idx;
          end
        end
      end
      default: next_state = S_IDLE;
    endcase
  end

  // A write landing on the index being fetched this cycle is forwarded (write-first).
  assign fetch_err  = load ? start_err : err;
  assign fetch_data = fetch_err ? '0 :
                      (MEM_WE && MEM_WADDR == fetch_idx) ? MEM_WDATA : mem[fetch_idx];

  always_ff @(posedge CLK) begin
    if (MEM_WE) mem[MEM_WADDR] <= MEM_WDATA;
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      idx   <= '0;
      burst <= '0;
      len   <= '0;
      beat  <= '0;
      err   <= 1'b0;
      rdata <= '0;
    end else begin
      if (load) begin
        idx   <= start_idx;
        burst <= RIT.ARBURST;
        len   <= RIT.ARLEN;
        beat  <= '0;
        err   <= start_err;
      end else if (fetch && state == S_BURST) begin
        idx  <= next_idx;
        beat <= beat + 8'd1;
      end
      if (fetch) rdata <= fetch_data;
    end
  end

  assign RIT.ARREADY = (state == S_IDLE);
  assign RIT.RVALID  = (state == S_BURST);
  assign RIT.RLAST   = (state == S_BURST) && last;
  assign RIT.RDATA   = rdata;
  assign RIT.RRESP   = err ? 2'b10 : 2'b00;

  assign unused_bits = ^{RIT.ARADDR[31:AW+4], RIT.ARADDR[3:0], LATENCY[0]};

endmodule

// File: tb/tb_leve_axir_mem.sv
// Table-driven bench for leve_axir_mem: burst vectors feed a beat scoreboard, plus reset/reset-abort sequences.
module tb_leve_axir_mem;
  localparam int DEPTH   = 1024;
  localparam int LATENCY = 3;
  localparam int AW      = $clog2(DEPTH);
`ifdef LEVE_AXIR_MEM_WAIT_EN
  localparam int LAT_EXP = 1 + LATENCY;
`else
  localparam int LAT_EXP = 1;
`endif
  localparam int W = 131;

  typedef struct {
    logic [1:0]  burst;
    logic [7:0]  len;
    logic [31:0] addr;
    int          first;
    logic [1:0]  resp;
    logic [15:0] rdy;
    bit          wr_en;
    int          wr_at;
    int          wr_idx;
  } vec_t;

  logic          CLK = 1'b0;
  logic          RSTn = 1'b0;
  logic          MEM_WE = 1'b0;
  logic [AW-1:0] MEM_WADDR = '0;
  logic [127:0]  MEM_WDATA = '0;
  AXIR rit();

  logic [127:0]  mirror [DEPTH];
  logic [W-1:0]  exp_q [$];
  vec_t          tbl [12];
  int            checks = 0;
  int            failures = 0;

  leve_axir_mem #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
    .CLK(CLK), .RSTn(RSTn), .MEM_WE(MEM_WE), .MEM_WADDR(MEM_WADDR),
    .MEM_WDATA(MEM_WDATA), .RIT(rit)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp_v);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic preload();
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge CLK);
      MEM_WE    = 1'b1;
      MEM_WADDR = AW'(i);
      MEM_WDATA = (i < 4) ? 128'(32'hA0 + i) : rnd128();
      mirror[i] = MEM_WDATA;
    end
    @(negedge CLK);
    MEM_WE = 1'b0;
  endtask

  task automatic run_burst(input vec_t v);
    int idx, n, lat, cyc, done;
    bit stalled, wr_flag;
    logic [127:0] d, wr_data;
    logic [W-1:0] act, held, exp_v;
    wr_data = rnd128();
    n = v.len + 1;
    for (int k = 0; k <= int'(v.len); k++) begin
      case (v.burst)
        2'd0:    idx = v.first;
        2'd1:    idx = (v.first + k) % DEPTH;
        default: idx = (v.first - v.first % n) + (v.first % n + k) % n;
      endcase
      if (v.resp != 2'b00) d = '0;
      else if (v.wr_en && k > v.wr_at && idx == v.wr_idx) d = wr_data;
      else d = mirror[idx];
      exp_q.push_back({k == int'(v.len), v.resp, d});
    end
    if (v.wr_en) mirror[v.wr_idx] = wr_data;

    @(negedge CLK);
    check("arready_idle", W'(rit.ARREADY), W'(1));
    rit.ARVALID = 1'b1;
    rit.ARBURST = v.burst;
    rit.ARLEN   = v.len;
    rit.ARADDR  = v.addr;
    @(posedge CLK);
    #1 rit.ARVALID = 1'b0;
    lat = 0;
    @(negedge CLK);
    while (!rit.RVALID && lat < 40) begin
      lat++;
      @(negedge CLK);
    end
    check("first_beat_latency", W'(lat + 1), W'(LAT_EXP));
    if (!rit.RVALID) begin
      exp_q.delete();
      return;
    end

    done = 0; cyc = 0; stalled = 0; wr_flag = 0; held = '0;
    while (done <= int'(v.len) && cyc < 2000) begin
      rit.RREADY = v.rdy[cyc % 16];
      if (v.wr_en && !wr_flag && done == v.wr_at) begin
        MEM_WE = 1'b1; MEM_WADDR = AW'(v.wr_idx); MEM_WDATA = wr_data; wr_flag = 1;
      end else begin
        MEM_WE = 1'b0;
      end
      act = {rit.RLAST, rit.RRESP, rit.RDATA};
      check("rvalid_in_burst", W'(rit.RVALID), W'(1));
      if (stalled) check("stall_hold", act, held);
      if (rit.RREADY) begin
        exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
        check("beat", act, exp_v);
        done++;
        stalled = 0;
      end else begin
        stalled = 1;
        held = act;
      end
      cyc++;
      @(negedge CLK);
    end
    rit.RREADY = 1'b0;
    MEM_WE = 1'b0;
    if (done <= int'(v.len)) check("beat_timeout", W'(done), W'(v.len + 1));
    exp_q.delete();
    check("arready_after_last", W'(rit.ARREADY), W'(1));
    check("rvalid_after_last", W'(rit.RVALID), W'(0));
  endtask

  initial begin
    rit.ARVALID = 1'b0; rit.ARADDR = '0; rit.ARBURST = '0; rit.ARLEN = '0; rit.RREADY = 1'b0;

    // Stimulus table: {burst, len, addr, expected start index, expected resp, ready pattern, write hook}
    tbl[0]  = '{2'd2, 8'd3,  32'h8000_0020, 2,     2'b00, 16'hFFFF, 0, 0, 0};
    tbl[1]  = '{2'd1, 8'd0,  32'h0000_0030, 3,     2'b00, 16'hFFFF, 0, 0, 0};
    tbl[2]  = '{2'd1, 8'd7,  32'h0000_3FC7, 1020,  2'b00, 16'h9999, 0, 0, 0};
    tbl[3]  = '{2'd2, 8'd2,  32'h0000_0040, 4,     2'b10, 16'hFFFF, 0, 0, 0};
    tbl[4]  = '{2'd3, 8'd1,  32'h0000_0050, 5,     2'b10, 16'h9999, 0, 0, 0};
    tbl[5]  = '{2'd2, 8'd7,  32'h0000_00D0, 13,    2'b00, 16'(($urandom_range(0, 16'hFFFF)) | 1), 0, 0, 0};
    tbl[6]  = '{2'd0, 8'd4,  32'h0123_4560, 'h56,  2'b00, 16'(($urandom_range(0, 16'hFFFF)) | 1), 0, 0, 0};
    tbl[7]  = '{2'd2, 8'd15, 32'h0000_3F50, 'h3F5, 2'b00, 16'(($urandom_range(0, 16'hFFFF)) | 1), 0, 0, 0};
    tbl[8]  = '{2'd0, 8'd3,  32'h0000_0050, 5,     2'b00, 16'h9999, 1, 1, 5};
    tbl[9]  = '{2'd0, 8'd2,  32'h0000_0070, 7,     2'b00, 16'hFFFF, 1, 0, 7};
    tbl[10] = '{2'd1, 8'd20, 32'h0000_3E80, 1000,  2'b00, 16'(($urandom_range(0, 16'hFFFF)) | 1), 0, 0, 0};
    tbl[11] = '{2'd2, 8'd1,  32'h0000_0090, 9,     2'b00, 16'hFFFF, 0, 0, 0};

    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("reset_arready", W'(rit.ARREADY), W'(1));
    check("reset_rvalid",  W'(rit.RVALID),  W'(0));
    check("reset_rlast",   W'(rit.RLAST),   W'(0));
    check("reset_rdata",   W'(rit.RDATA),   W'(0));
    check("reset_rresp",   W'(rit.RRESP),   W'(0));
    RSTn = 1'b1;

    preload();
    for (int i = 0; i < 12; i++) run_burst(tbl[i]);

    // Reset during beat 2 of a 4-beat INCR burst, then a fresh burst elsewhere.
    @(negedge CLK);
    rit.ARVALID = 1'b1; rit.ARBURST = 2'd1; rit.ARLEN = 8'd3; rit.ARADDR = 32'h0000_0320;
    @(posedge CLK);
    #1 rit.ARVALID = 1'b0;
    rit.RREADY = 1'b1;
    repeat (LAT_EXP) @(negedge CLK);
    repeat (2) @(negedge CLK);
    rit.RREADY = 1'b0;
    check("pre_reset_beat2", {rit.RLAST, rit.RRESP, rit.RDATA}, {1'b0, 2'b00, mirror[52]});
    RSTn = 1'b0;
    #1;
    check("reset_drops_rvalid", W'(rit.RVALID), W'(0));
    @(negedge CLK);
    RSTn = 1'b1;
    @(negedge CLK);
    check("post_reset_arready", W'(rit.ARREADY), W'(1));
    check("post_reset_rvalid",  W'(rit.RVALID),  W'(0));
    run_burst('{2'd1, 8'd1, 32'h0000_03C0, 60, 2'b00, 16'hFFFF, 0, 0, 0});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/leve_axir_mem.md
# leve_axir_mem

AXI read responder (target end of the `AXIR` interface) backed by a 128-bit-wide synchronous memory array. It serves the instruction-fetch read initiator and any other `AXIR.init` master: it accepts one AR request at a time, then returns `ARLEN+1` beats using FIXED, INCR or WRAP addressing. A side write port preloads or patches memory contents for simulation and boot images.

## Interface
Parameters:
- `DEPTH`, 1024: number of 128-bit words; power of two; `AW = $clog2(DEPTH)`.
- `LATENCY`, 2: extra wait cycles between AR handshake and first R beat (used only with `LEVE_AXIR_MEM_WAIT_EN`); legal range 1..15.

Ports:
- `CLK`  in  1: clock.
- `RSTn`  in  1: reset, asynchronous, active-low.
- `MEM_WE`  in  1: preload write strobe.
- `MEM_WADDR`  in  AW: preload word index.
- `MEM_WDATA`  in  128: preload data.
- `RIT`  `AXIR.target`: drives `ARREADY`, `RVALID`, `RDATA[127:0]`, `RLAST`, `RRESP[1:0]`; samples `ARVALID`, `ARADDR`, `ARBURST`, `ARLEN[7:0]`, `RREADY`.

## Operation
- FSM states: IDLE, WAIT (exists only with the macro), BURST.
- IDLE: `ARREADY=1`. On `ARVALID&&ARREADY`, latch the start index `idx=ARADDR[AW+3:4]`, the burst type, `len=ARLEN` and `beat=0`. Upper address bits and `ARADDR[3:0]` are ignored; the index wraps modulo DEPTH.
- WAIT: `ARREADY=0`, `RVALID=0`; a counter loads `LATENCY-1` and counts down; at 0 the FSM goes to BURST with the first beat presented.
- BURST: `ARREADY=0`, `RVALID=1`. `RDATA` is registered, holding `mem[idx]`. `RLAST=(beat==len)`. On `RVALID&&RREADY`: if `RLAST`, go to IDLE and drop `RVALID`; otherwise `beat++`, advance `idx` and load `RDATA` from the new index.
- Index advance:
  - FIXED (0): unchanged.
  - INCR (1): `idx+1` modulo DEPTH.
  - WRAP (2): the low `log2(len+1)` bits increment and wrap; the upper bits are held.
- Errors: WRAP with `len` not in {1,3,7,15}, or `ARBURST==3`, gives `RRESP=2'b10` (SLVERR) with `RDATA=0` on every beat. The beat count is still `len+1`. Otherwise `RRESP=2'b00`.
- Preload write: `mem[MEM_WADDR]<=MEM_WDATA` on any cycle.
  - An already-registered `RDATA` is not changed.
  - A beat fetched in the same cycle as a write to the same index returns the new data (write-first).
- `RRESP` is held constant for the whole burst.

## Timing
- Reset values: state IDLE, so `ARREADY=1` after reset; `RVALID=0`, `RLAST=0`, `RDATA=0`, `RRESP=0`. The memory array is not reset.
- Without the macro: AR handshake in cycle N gives the first beat valid in N+1.
- With the macro: the first beat is valid in N+1+LATENCY.
- Back-to-back beats run at 1 per cycle while `RREADY=1`.
- `RREADY=0` stalls the beat: `RDATA`, `RLAST` and `RRESP` are held stable.
- Next AR accepted: cycle N+1 after the last handshake in N, because `ARREADY` rises in N+1. There is no AR/R overlap.
- Asynchronous reset mid-burst aborts the burst. `RVALID` drops immediately, and no partial beat is replayed after reset.

## Configuration
- `LEVE_AXIR_MEM_WAIT_EN` defined: the WAIT state and its 4-bit countdown exist, and first-beat latency is `1+LATENCY`.
- Not defined: WAIT is removed, IDLE goes directly to BURST, and the `LATENCY` parameter is ignored.

## Test plan
- **WRAP burst:** preload words 0..3 = 0xA0..0xA3; WRAP `ARLEN=3`, `ARADDR=0x8000_0020` -> beats 0xA2, 0xA3, 0xA0, 0xA1; `RLAST` only on beat 4; `RRESP=0`.
- **Single-beat INCR:** INCR `ARLEN=0`, `ARADDR=0x30` -> one beat `mem[3]`; `RLAST=1` with `RVALID`; `ARREADY` high the next cycle.
- **Backpressure:** INCR `ARLEN=7`, `RREADY` toggled 1,0,0,1... -> 8 beats in order `mem[i..i+7]`; data held stable while stalled; `RDATA` wraps from index DEPTH-1 to 0.
- **Illegal WRAP length:** WRAP `ARLEN=2` -> 3 beats, each `RRESP=2'b10`, `RDATA=0`, last flagged.
- **Wait latency:** macro on, `LATENCY=3` -> first `RVALID` exactly 4 cycles after the AR handshake; macro off -> 1 cycle.
- **Reset mid-burst:** `RSTn` low during beat 2 of 4 -> `RVALID=0` and `ARREADY=1` after release; a new AR returns a fresh burst starting at its own address.
